uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
//  UART receive path, the counterpart of the TX serializer.
//  Oversamples the asynchronous serial line, detects the start bit, recovers DATA_WIDTH data bits LSB-first,
//  checks the optional parity bit and the stop bit, then presents the parallel byte with a one-cycle valid strobe.
//  Sits between the RX pad and the UART RX FIFO/register interface. Driven by the shared baud generator oversample tick.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame (5..8)
//  PRESCALE    8  RX_tick pulses per bit period; even, >=6
// PORTS
//  CLK         in   1           system clock, all logic on rising edge
//  RST         in   1           asynchronous, active-high reset
//  RX_IN       in   1           asynchronous serial line, idle high
//  RX_tick     in   1           oversample enable, 1-CLK pulse, PRESCALE per bit
//  PAR_EN      in   1           1 = frame carries a parity bit after the data bits
//  PAR_TYP     in   1           0 = even, 1 = odd parity
//  P_DATA      out  DATA_WIDTH  last correctly received data word
//  data_valid  out  1           1-CLK pulse: P_DATA updated with a good frame
//  par_err     out  1           1-CLK pulse: parity mismatch on the frame just ended
//  stp_err     out  1           1-CLK pulse: stop bit sampled 0
//  busy        out  1           1 while not in IDLE
// BEHAVIOUR
//  Reset: P_DATA=0, data_valid=0, par_err=0, stp_err=0, busy=0, FSM=IDLE.
//   Counters are cleared. Synchronizer flops are set to 1. Reset mid-frame aborts the frame; no strobe is emitted.
//  RX_IN passes through a 2-flop synchronizer (rx_s). All FSM and counter activity advances only on CLK edges with RX_tick=1.
//  Tick counter tcnt runs 0..PRESCALE-1 inside each bit and wraps to 0 when the bit ends.
//  Bit sampling: rx_s is captured at tcnt=PRESCALE/2-1 and at tcnt=PRESCALE/2.
//   The bit value is the majority of those two samples plus rx_s at tcnt=PRESCALE/2+1, the decision tick.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//  IDLE:   on a tick with rx_s=0 -> START, tcnt=1 (the detecting tick counts as tick 0).
//  START:  decision=1 (glitch) -> IDLE, no outputs.
//          decision=0 -> stay until tcnt=PRESCALE-1, then -> DATA with bcnt=0.
//  DATA:   decision shifted into shift register MSB side (LSB-first line order).
//          At bit end bcnt++. After bcnt=DATA_WIDTH-1 completes: -> PARITY if PAR_EN, else -> STOP.
//  PARITY: decision stored.
//          Expected parity = ^data for even, ~^data for odd, so that data plus parity holds an even/odd count of ones.
//          At bit end -> STOP.
//  STOP:   on the decision tick (tcnt=PRESCALE/2+1) the frame is resolved and the FSM -> IDLE immediately.
//          It does not wait for the bit end, so a following start bit is caught.
//  Frame resolution, outputs registered and visible the CLK cycle after the decision tick, each for exactly 1 CLK:
//   stop=1 and parity ok (or PAR_EN=0) -> P_DATA<=shift register, data_valid=1.
//   parity mismatch -> par_err=1.
//   stop=0 -> stp_err=1.
//   Both errors may assert together. On any error data_valid stays 0 and P_DATA holds its previous value.
//  PAR_EN/PAR_TYP are sampled on IDLE->START and held for the frame. Changes mid-frame are ignored.
//  A line held low (break) after a stop error: the FSM re-enters START on the next tick. No special break handling.
//  busy = (state != IDLE), registered.
// TESTING
//  PRESCALE=8, DATA_WIDTH=8, RX_tick every 2nd CLK unless noted.
//  T1: PAR_EN=0, frame 0xA5 ->
//      one data_valid pulse, P_DATA=0xA5, par_err=stp_err=0.
//  T2: PAR_EN=1, PAR_TYP=0, 0x37 with parity bit 1 -> data_valid, P_DATA=0x37.
//      Same frame with parity bit 0 -> par_err pulse, no data_valid, P_DATA stays 0x37.
//  T3: 0x81 with stop bit driven 0 -> stp_err pulse, no data_valid.
//      FSM re-enters START while the line is low.
//      After the line returns high, frame 0x42 -> P_DATA=0x42.
//  T4: line low for 2 ticks only, then high -> back to IDLE, no strobes, busy drops.
//      1-tick low glitch at tcnt=PRESCALE/2 of data bit 3 of 0xFF -> P_DATA=0xFF (majority).
//  T5: RST asserted after 3 data bits of 0xC3 -> all outputs 0 immediately, busy=0.
//      After release, full frame 0xC3 -> P_DATA=0xC3.
//  T6: back-to-back 0x00 and 0xFF with 1 stop bit and no idle gap, RX_tick every CLK -> two data_valid pulses, values in order.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start detection, 3-sample majority bit recovery,
// optional parity and stop checking, single-cycle result strobes.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  RX_tick,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int TW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [TW-1:0] T_S0  = TW'(PRESCALE/2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(PRESCALE/2);
  localparam logic [TW-1:0] T_DEC = TW'(PRESCALE/2 + 1);
  localparam logic [TW-1:0] T_END = TW'(PRESCALE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                  r_rx_meta;
  logic                  r_rx_s;
  logic [2:0]            r_state;
  logic [TW-1:0]         r_tcnt;
  logic [BW-1:0]         r_bcnt;
  logic                  r_s0;
  logic                  r_s1;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_dv;
  logic                  r_pe;
  logic                  r_se;
  logic                  r_busy;

  logic       w_start;
  logic       w_dec_tick;
  logic       w_bit_end;
  logic       w_decision;
  logic       w_par_exp;
  logic       w_par_ok;
  logic [2:0] w_state_nxt;

  assign w_start    = (r_state == S_IDLE) && RX_tick && !r_rx_s;
  assign w_dec_tick = RX_tick && (r_tcnt == T_DEC);
  assign w_bit_end  = RX_tick && (r_tcnt == T_END);
  // Two captured samples plus the live one on the decision tick form the majority vote.
  assign w_decision = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
  assign w_par_exp  = r_par_typ ? ~^r_shift : ^r_shift;
  assign w_par_ok   = !r_par_en || (r_par_bit == w_par_exp);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_START;
      S_START: begin
        if (w_dec_tick && w_decision) w_state_nxt = S_IDLE;
        else if (w_bit_end)           w_state_nxt = S_DATA;
      end
      S_DATA:   if (w_bit_end && (r_bcnt == B_LAST)) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP:   if (w_dec_tick) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RX_IN;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_tcnt    <= '0;
      r_bcnt    <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (RX_tick) begin
        // The detecting tick is tick 0 of the start bit, so counting resumes at 1.
        if (r_state == S_IDLE)
          r_tcnt <= w_start ? TW'(1) : '0;
        else if ((w_state_nxt == S_IDLE) || (r_tcnt == T_END))
          r_tcnt <= '0;
        else
          r_tcnt <= r_tcnt + TW'(1);
        if (r_tcnt == T_S0) r_s0 <= r_rx_s;
        if (r_tcnt == T_S1) r_s1 <= r_rx_s;
      end
      if (w_bit_end && (r_state == S_START)) r_bcnt <= '0;
      else if (w_bit_end && (r_state == S_DATA)) r_bcnt <= r_bcnt + BW'(1);
      if (w_dec_tick && (r_state == S_DATA))
        r_shift <= {w_decision, r_shift[DATA_WIDTH-1:1]};
      if (w_dec_tick && (r_state == S_PARITY))
        r_par_bit <= w_decision;
      if (w_start) begin
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
      end
    end
  end

  // The frame resolves on the stop bit's decision tick, not at its end, so a following start bit is caught.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data <= '0;
      r_dv   <= 1'b0;
      r_pe   <= 1'b0;
      r_se   <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_se <= 1'b0;
      if (w_dec_tick && (r_state == S_STOP)) begin
        r_dv <= w_decision && w_par_ok;
        r_pe <= !w_par_ok;
        r_se <= !w_decision;
        if (w_decision && w_par_ok) r_data <= r_shift;
      end
    end
  end

  assign P_DATA     = r_data;
  assign data_valid = r_dv;
  assign par_err    = r_pe;
  assign stp_err    = r_se;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: frame driver tasks, scoreboard on data_valid, per-scenario checks.
module tb_uart_rx_deserializer;
  localparam int DW = 8;
  localparam int PS = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          RX_tick;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_div = 2;
  int cnt_dv = 0;
  int cnt_pe = 0;
  int cnt_se = 0;
  logic [DW-1:0] exp_q[$];

  uart_rx_deserializer #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .RX_tick(RX_tick), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and oversample tick generation
  always #5 CLK = ~CLK;

  initial begin : tick_gen
    int div_cnt;
    div_cnt = 0;
    RX_tick = 1'b0;
    forever begin
      @(negedge CLK);
      div_cnt++;
      if (div_cnt >= tick_div) begin
        div_cnt = 0;
        RX_tick = 1'b1;
      end else begin
        RX_tick = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bench did not finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every data_valid pulse pops the oldest expected word
  always @(negedge CLK) begin : monitor
    logic [DW-1:0] e;
    if (data_valid) begin
      cnt_dv++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: data_valid with P_DATA=%h, expected no word", P_DATA);
      end else begin
        e = exp_q.pop_front();
        if (P_DATA !== e) begin
          n_bad++;
          $display("FAIL sb_data: P_DATA=%h expected %h", P_DATA, e);
        end
      end
    end
    if (par_err) cnt_pe++;
    if (stp_err) cnt_se++;
  end

  // Driver tasks
  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge CLK);
      if (RX_tick) k++;
    end
  endtask

  task automatic drive(input logic v, input int n);
    #1 RX_IN = v;
    wait_ticks(n);
  endtask

  function automatic logic par_of(input logic [DW-1:0] d, input logic typ);
    return typ ? ~^d : ^d;
  endfunction

  // gbit selects a data bit that gets a one-tick inverted glitch on its middle sample (-1 = none)
  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pbit,
                            input logic sbit, input int gbit);
    drive(1'b0, PS);
    for (int i = 0; i < DW; i++) begin
      if (i == gbit) begin
        drive(d[i], PS/2);
        drive(~d[i], 1);
        drive(d[i], PS/2 - 1);
      end else begin
        drive(d[i], PS);
      end
    end
    if (pe) drive(pbit, PS);
    drive(sbit, PS);
  endtask

  // Scenarios
  task automatic test_reset();
    RST = 1'b1;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if (P_DATA !== 8'h00) begin
      n_bad++; $display("FAIL reset_pdata: got %h expected 00", P_DATA);
    end
    n_cmp++;
    if ({data_valid, par_err, stp_err, busy} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: dv/pe/se/busy=%b expected 0000", {data_valid, par_err, stp_err, busy});
    end
    n_cmp++;
    if (dbg_state !== 3'd0) begin
      n_bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(posedge CLK);
  endtask

  task automatic test_no_parity();
    int dv0, pe0, se0;
    dv0 = cnt_dv; pe0 = cnt_pe; se0 = cnt_se;
    PAR_EN = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 4);
    n_cmp++;
    if (cnt_dv - dv0 !== 1) begin
      n_bad++; $display("FAIL t1_dv_count: got %0d pulses expected 1", cnt_dv - dv0);
    end
    n_cmp++;
    if ((cnt_pe - pe0) + (cnt_se - se0) !== 0) begin
      n_bad++; $display("FAIL t1_err_count: got %0d error pulses expected 0", (cnt_pe - pe0) + (cnt_se - se0));
    end
    n_cmp++;
    if (P_DATA !== 8'hA5) begin
      n_bad++; $display("FAIL t1_pdata: got %h expected a5", P_DATA);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL t1_busy_idle: got %b expected 0", busy);
    end
  endtask

  task automatic test_parity();
    int dv0, pe0;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    exp_q.push_back(8'h37);
    send_frame(8'h37, 1'b1, 1'b1, 1'b1, -1);
    drive(1'b1, 4);
    n_cmp++;
    if (P_DATA !== 8'h37) begin
      n_bad++; $display("FAIL t2_even_ok: P_DATA=%h expected 37", P_DATA);
    end
    dv0 = cnt_dv; pe0 = cnt_pe;
    send_frame(8'h37, 1'b1, 1'b0, 1'b1, -1);
    drive(1'b1, 4);
    n_cmp++;
    if (cnt_pe - pe0 !== 1) begin
      n_bad++; $display("FAIL t2_par_err: got %0d pulses expected 1", cnt_pe - pe0);
    end
    n_cmp++;
    if (cnt_dv - dv0 !== 0) begin
      n_bad++; $display("FAIL t2_no_dv: got %0d pulses expected 0", cnt_dv - dv0);
    end
    n_cmp++;
    if (P_DATA !== 8'h37) begin
      n_bad++; $display("FAIL t2_hold: P_DATA=%h expected 37", P_DATA);
    end
    PAR_TYP = 1'b1;
    exp_q.push_back(8'h5C);
    send_frame(8'h5C, 1'b1, par_of(8'h5C, 1'b1), 1'b1, -1);
    drive(1'b1, 4);
    n_cmp++;
    if (P_DATA !== 8'h5C) begin
      n_bad++; $display("FAIL t2_odd_ok: P_DATA=%h expected 5c", P_DATA);
    end
    // Parity type flips mid-frame; the frame must still be judged as even parity
    PAR_TYP = 1'b0;
    pe0 = cnt_pe;
    exp_q.push_back(8'h01);
    fork
      send_frame(8'h01, 1'b1, par_of(8'h01, 1'b0), 1'b1, -1);
      begin
        wait_ticks(20);
        PAR_TYP = 1'b1;
      end
    join
    drive(1'b1, 4);
    n_cmp++;
    if ((cnt_pe - pe0 !== 0) || (P_DATA !== 8'h01)) begin
      n_bad++; $display("FAIL t2_typ_held: par_err pulses=%0d P_DATA=%h expected 0 and 01", cnt_pe - pe0, P_DATA);
    end
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
  endtask

  task automatic test_stop_error();
    int dv0, se0;
    logic [DW-1:0] prev;
    prev = P_DATA;
    dv0 = cnt_dv; se0 = cnt_se;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1);
    #1;
    n_cmp++;
    if ((dbg_state !== 3'd1) || (busy !== 1'b1)) begin
      n_bad++; $display("FAIL t3_break_start: state=%0d busy=%b expected 1 and 1", dbg_state, busy);
    end
    drive(1'b1, 12);
    n_cmp++;
    if ((cnt_se - se0 !== 1) || (cnt_dv - dv0 !== 0)) begin
      n_bad++; $display("FAIL t3_stp_err: stp_err=%0d dv=%0d pulses expected 1 and 0", cnt_se - se0, cnt_dv - dv0);
    end
    n_cmp++;
    if ((P_DATA !== prev) || (busy !== 1'b0)) begin
      n_bad++; $display("FAIL t3_hold: P_DATA=%h busy=%b expected %h and 0", P_DATA, busy, prev);
    end
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 4);
    n_cmp++;
    if (P_DATA !== 8'h42) begin
      n_bad++; $display("FAIL t3_recover: P_DATA=%h expected 42", P_DATA);
    end
  endtask

  task automatic test_glitch();
    int dv0, pe0, se0;
    dv0 = cnt_dv; pe0 = cnt_pe; se0 = cnt_se;
    drive(1'b0, 2);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL t4_busy_start: got %b expected 1", busy);
    end
    drive(1'b1, 10);
    n_cmp++;
    if ((busy !== 1'b0) || (dbg_state !== 3'd0)) begin
      n_bad++; $display("FAIL t4_false_start: busy=%b state=%0d expected 0 and 0", busy, dbg_state);
    end
    n_cmp++;
    if ((cnt_dv - dv0) + (cnt_pe - pe0) + (cnt_se - se0) !== 0) begin
      n_bad++; $display("FAIL t4_no_strobe: got %0d strobes expected 0", (cnt_dv - dv0) + (cnt_pe - pe0) + (cnt_se - se0));
    end
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 3);
    drive(1'b1, 4);
    n_cmp++;
    if (P_DATA !== 8'hFF) begin
      n_bad++; $display("FAIL t4_majority: P_DATA=%h expected ff", P_DATA);
    end
  endtask

  task automatic test_reset_midframe();
    int dv0;
    dv0 = cnt_dv;
    drive(1'b0, PS);
    drive(1'b1, PS);
    drive(1'b1, PS);
    drive(1'b0, PS);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({P_DATA, data_valid, par_err, stp_err, busy} !== 12'h000 || dbg_state !== 3'd0) begin
      n_bad++; $display("FAIL t5_async_reset: P_DATA=%h dv/pe/se/busy=%b state=%0d expected all 0",
                        P_DATA, {data_valid, par_err, stp_err, busy}, dbg_state);
    end
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    n_cmp++;
    if (cnt_dv - dv0 !== 0) begin
      n_bad++; $display("FAIL t5_aborted: got %0d dv pulses expected 0", cnt_dv - dv0);
    end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 4);
    n_cmp++;
    if (P_DATA !== 8'hC3) begin
      n_bad++; $display("FAIL t5_after_reset: P_DATA=%h expected c3", P_DATA);
    end
  endtask

  task automatic test_back_to_back();
    int dv0;
    tick_div = 1;
    repeat (4) @(posedge CLK);
    dv0 = cnt_dv;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 6);
    n_cmp++;
    if ((cnt_dv - dv0 !== 2) || (exp_q.size() !== 0)) begin
      n_bad++; $display("FAIL t6_b2b: got %0d dv pulses, %0d words pending; expected 2 and 0", cnt_dv - dv0, exp_q.size());
    end
    n_cmp++;
    if (P_DATA !== 8'hFF) begin
      n_bad++; $display("FAIL t6_last: P_DATA=%h expected ff", P_DATA);
    end
    tick_div = 2;
    repeat (4) @(posedge CLK);
  endtask

  task automatic test_random();
    int dv0, err0;
    logic [DW-1:0] d;
    logic typ;
    dv0 = cnt_dv; err0 = cnt_pe + cnt_se;
    for (int i = 0; i < 8; i++) begin
      d = DW'($urandom_range(0, 255));
      typ = 1'($urandom_range(0, 1));
      PAR_EN = 1'($urandom_range(0, 1));
      PAR_TYP = typ;
      exp_q.push_back(d);
      send_frame(d, PAR_EN, par_of(d, typ), 1'b1, -1);
      drive(1'b1, $urandom_range(1, 6));
    end
    drive(1'b1, 4);
    n_cmp++;
    if ((cnt_dv - dv0 !== 8) || (cnt_pe + cnt_se - err0 !== 0) || (exp_q.size() !== 0)) begin
      n_bad++; $display("FAIL rand_frames: dv=%0d errs=%0d pending=%0d expected 8, 0, 0",
                        cnt_dv - dv0, cnt_pe + cnt_se - err0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_stop_error();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
